// File: rtl/x9_pkg.sv
// Shared types and constants for the x9 front end.
// Holds the instruction encodings and the program image used by inst_rom.
package x9_pkg;

    localparam int X9_A   = 4;
    localparam int X9_W   = 9;
    localparam int OPC_W  = 4;

    localparam logic [OPC_W-1:0] OP_ADD  = 4'h1;
    localparam logic [OPC_W-1:0] OP_SUB  = 4'h2;
    localparam logic [OPC_W-1:0] OP_AND  = 4'h3;
    localparam logic [OPC_W-1:0] OP_OR   = 4'h4;
    localparam logic [OPC_W-1:0] OP_XOR  = 4'h5;
    localparam logic [OPC_W-1:0] OP_SLL  = 4'h6;
    localparam logic [OPC_W-1:0] OP_SRL  = 4'h7;
    localparam logic [OPC_W-1:0] OP_LD   = 4'h8;
    localparam logic [OPC_W-1:0] OP_ST   = 4'h9;
    localparam logic [OPC_W-1:0] OP_BEQ  = 4'hA;
    localparam logic [OPC_W-1:0] OP_BNE  = 4'hB;
    localparam logic [OPC_W-1:0] OP_JMP  = 4'hC;
    localparam logic [OPC_W-1:0] OP_LI   = 4'hD;
    localparam logic [OPC_W-1:0] OP_MOV  = 4'hE;
    localparam logic [OPC_W-1:0] OP_HALT = 4'hF;

    localparam logic [X9_W-1:0] NOP = '0;

    typedef enum logic [1:0] {
        FILL   = 2'd0,
        RUN    = 2'd1,
        HALTED = 2'd2
    } fd_state_t;

    // Program image: opcode in the top nibble, low bits tag the address.
    function automatic logic [X9_W-1:0] rom_word(input int unsigned a);
        logic [X9_W-1:0] w;
        case (a)
            0:       w = {OP_ADD,  5'd0};
            1:       w = {OP_SUB,  5'd1};
            2:       w = {OP_AND,  5'd2};
            3:       w = {OP_OR,   5'd3};
            4:       w = {OP_XOR,  5'd4};
            5:       w = {OP_HALT, 5'd5};
            6:       w = {OP_SLL,  5'd6};
            7:       w = {OP_SRL,  5'd7};
            8:       w = {OP_LD,   5'd8};
            9:       w = {OP_ST,   5'd9};
            10:      w = {OP_BEQ,  5'd10};
            11:      w = {OP_BNE,  5'd11};
            12:      w = {OP_JMP,  5'd12};
            13:      w = {OP_LI,   5'd13};
            14:      w = {OP_MOV,  5'd14};
            15:      w = {OP_ADD,  5'd15};
            default: w = NOP;
        endcase
        return w;
    endfunction

endpackage

// File: rtl/inst_rom.sv
// Synchronous-read instruction ROM.
// Data for i_addr appears on o_data one cycle after a cycle with i_en high.
module inst_rom
    import x9_pkg::*;
#(
    parameter int A = X9_A,
    parameter int W = X9_W
) (
    input  logic         i_clk,
    input  logic         i_en,
    input  logic [A-1:0] i_addr,
    output logic [W-1:0] o_data
);

    logic [W-1:0] r_data;
    logic [X9_W-1:0] w_word;

    assign w_word = rom_word(32'(i_addr));

    // Registered read; a held enable keeps the last word for a stalled consumer.
    always_ff @(posedge i_clk) begin
        if (i_en) begin
            r_data <= W'(w_word);
        end
    end

    assign o_data = r_data;

endmodule

// File: rtl/fetch_decode_reg.sv
// IF->ID stage: fetches from the ROM at the PC and registers it for decode.
// Handles flush bubbles, stall hold and the sticky HALT front-end freeze.
module fetch_decode_reg
    import x9_pkg::*;
#(
    parameter int A = X9_A,
    parameter int W = X9_W
) (
    input  logic         i_clk,
    input  logic         i_reset,
    input  logic [A-1:0] i_pc,
    input  logic         i_stall,
    input  logic         i_flush,
    output logic [W-1:0] o_inst,
    output logic [A-1:0] o_inst_pc,
    output logic         o_inst_valid,
    output logic         o_halt_out,
    output logic         o_halted
);

    fd_state_t    r_state;
    fd_state_t    w_state_nxt;
    logic [A-1:0] r_pc_q;
    logic [A-1:0] w_pc_q_nxt;
    logic [W-1:0] r_inst;
    logic [W-1:0] w_inst_nxt;
    logic [A-1:0] r_inst_pc;
    logic [A-1:0] w_inst_pc_nxt;
    logic         r_valid;
    logic         w_valid_nxt;
    logic [W-1:0] w_rom_q;
    logic         w_rom_en;
    logic         w_is_halt;

    // The ROM word must stay paired with r_pc_q, so it holds exactly when r_pc_q does.
    assign w_rom_en = i_flush | ~i_stall;

    inst_rom #(
        .A (A),
        .W (W)
    ) u_rom (
        .i_clk  (i_clk),
        .i_en   (w_rom_en),
        .i_addr (i_pc),
        .o_data (w_rom_q)
    );

    assign w_is_halt = (w_rom_q[W-1 -: OPC_W] == OP_HALT);

    // State register.
    always_ff @(posedge i_clk) begin
        if (i_reset) begin
            r_state <= FILL;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    // Next state and next output-register values; flush beats stall beats issue.
    always_comb begin
        w_state_nxt   = r_state;
        w_pc_q_nxt    = r_pc_q;
        w_inst_nxt    = r_inst;
        w_inst_pc_nxt = r_inst_pc;
        w_valid_nxt   = r_valid;
        if (i_flush) begin
            w_inst_nxt  = W'(NOP);
            w_valid_nxt = 1'b0;
            w_pc_q_nxt  = i_pc;
            if (r_state == FILL) begin
                w_state_nxt = RUN;
            end
        end else if (!i_stall) begin
            w_pc_q_nxt = i_pc;
            unique case (r_state)
                FILL: begin
                    w_inst_nxt  = W'(NOP);
                    w_valid_nxt = 1'b0;
                    w_state_nxt = RUN;
                end
                RUN: begin
                    w_inst_nxt    = w_rom_q;
                    w_inst_pc_nxt = r_pc_q;
                    w_valid_nxt   = 1'b1;
                    if (w_is_halt) begin
                        w_state_nxt = HALTED;
                    end
                end
                HALTED: begin
                    w_inst_nxt  = W'(NOP);
                    w_valid_nxt = 1'b0;
                end
                default: begin
                    w_state_nxt = FILL;
                end
            endcase
        end
    end

    // Fetch-address tag and decode-facing output registers.
    always_ff @(posedge i_clk) begin
        if (i_reset) begin
            r_pc_q    <= '0;
            r_inst    <= W'(NOP);
            r_inst_pc <= '0;
            r_valid   <= 1'b0;
        end else begin
            r_pc_q    <= w_pc_q_nxt;
            r_inst    <= w_inst_nxt;
            r_inst_pc <= w_inst_pc_nxt;
            r_valid   <= w_valid_nxt;
        end
    end

    assign o_inst       = r_inst;
    assign o_inst_pc    = r_inst_pc;
    assign o_inst_valid = r_valid;
    assign o_halted     = (r_state == HALTED);
    assign o_halt_out   = (r_state == HALTED) | i_stall;

endmodule

// File: tb/tb_fetch_decode_reg.sv
// Directed bench for fetch_decode_reg with a queue-based scoreboard.
// The driver pushes the expected post-edge outputs; the monitor pops and checks.
module tb_fetch_decode_reg;

    localparam int A = 4;
    localparam int W = 9;

    logic         clk;
    logic         reset;
    logic [A-1:0] pc;
    logic         stall;
    logic         flush;
    logic [W-1:0] inst;
    logic [A-1:0] inst_pc;
    logic         inst_valid;
    logic         halt_out;
    logic         halted;

    typedef struct {
        string        name;
        logic [W-1:0] inst;
        int           ipc;
        logic         v;
        logic         h;
        logic         ho;
    } exp_t;

    exp_t         q[$];
    logic [W-1:0] rom_t[16];
    int           n_vec;
    int           n_err;

    fetch_decode_reg #(
        .A (A),
        .W (W)
    ) dut (
        .i_clk        (clk),
        .i_reset      (reset),
        .i_pc         (pc),
        .i_stall      (stall),
        .i_flush      (flush),
        .o_inst       (inst),
        .o_inst_pc    (inst_pc),
        .o_inst_valid (inst_valid),
        .o_halt_out   (halt_out),
        .o_halted     (halted)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // One cycle of stimulus; ipc < 0 means inst_pc is not checked.
    task automatic step(input string nm, input logic r, input int p,
                        input logic s, input logic f, input int ipc,
                        input logic v, input logic h, input logic ho);
        exp_t e;
        @(negedge clk);
        reset = r;
        pc    = A'(p);
        stall = s;
        flush = f;
        e.name = nm;
        e.ipc  = ipc;
        e.v    = v;
        e.h    = h;
        e.ho   = ho;
        e.inst = (v && ipc >= 0) ? rom_t[ipc] : '0;
        q.push_back(e);
    endtask

    // Monitor: compare each registered output set just after the edge.
    initial begin
        exp_t e;
        logic ok;
        forever begin
            @(posedge clk);
            #1;
            if (q.size() > 0) begin
                e  = q.pop_front();
                ok = (inst == e.inst) && (inst_valid == e.v) &&
                     (halted == e.h) && (halt_out == e.ho) &&
                     (e.ipc < 0 || int'(inst_pc) == e.ipc);
                n_vec++;
                if (!ok) begin
                    n_err++;
                    $display("FAIL %s: got inst=%h pc=%0d v=%b h=%b ho=%b, want inst=%h pc=%0d v=%b h=%b ho=%b",
                             e.name, inst, inst_pc, inst_valid, halted, halt_out,
                             e.inst, e.ipc, e.v, e.h, e.ho);
                end
            end
        end
    end

    initial begin
        n_vec = 0;
        n_err = 0;
        rom_t[0]  = {4'h1, 5'd0};
        rom_t[1]  = {4'h2, 5'd1};
        rom_t[2]  = {4'h3, 5'd2};
        rom_t[3]  = {4'h4, 5'd3};
        rom_t[4]  = {4'h5, 5'd4};
        rom_t[5]  = {4'hF, 5'd5};
        rom_t[6]  = {4'h6, 5'd6};
        rom_t[7]  = {4'h7, 5'd7};
        rom_t[8]  = {4'h8, 5'd8};
        rom_t[9]  = {4'h9, 5'd9};
        rom_t[10] = {4'hA, 5'd10};
        rom_t[11] = {4'hB, 5'd11};
        rom_t[12] = {4'hC, 5'd12};
        rom_t[13] = {4'hD, 5'd13};
        rom_t[14] = {4'hE, 5'd14};
        rom_t[15] = {4'h1, 5'd15};
        reset = 1'b1;
        pc    = '0;
        stall = 1'b0;
        flush = 1'b0;

        // reset, fill, in-order issue
        step("rst0",   1, 0,  0, 0,  0, 0, 0, 0);
        step("rst1",   1, 0,  0, 0,  0, 0, 0, 0);
        step("fill",   0, 0,  0, 0, -1, 0, 0, 0);
        step("iss0",   0, 1,  0, 0,  0, 1, 0, 0);
        step("iss1",   0, 2,  0, 0,  1, 1, 0, 0);
        step("iss2",   0, 3,  0, 0,  2, 1, 0, 0);
        // stall three cycles, PC stage holds at 4
        step("stl0",   0, 4,  1, 0,  2, 1, 0, 1);
        step("stl1",   0, 4,  1, 0,  2, 1, 0, 1);
        step("stl2",   0, 4,  1, 0,  2, 1, 0, 1);
        step("rel",    0, 4,  0, 0,  3, 1, 0, 0);
        // branch to 9
        step("fl9",    0, 9,  0, 1, -1, 0, 0, 0);
        step("tgt9",   0, 10, 0, 0,  9, 1, 0, 0);
        step("iss10",  0, 11, 0, 0, 10, 1, 0, 0);
        // back-to-back flushes, HALT at 5 squashed, flush+stall
        step("bb0",    0, 2,  0, 1, -1, 0, 0, 0);
        step("bb1",    0, 5,  0, 1, -1, 0, 0, 0);
        step("sqhalt", 0, 6,  1, 1, -1, 0, 0, 1);
        step("iss6",   0, 7,  0, 0,  6, 1, 0, 0);
        step("iss7",   0, 8,  0, 0,  7, 1, 0, 0);
        // real HALT at 5
        step("fl4",    0, 4,  0, 1, -1, 0, 0, 0);
        step("iss4",   0, 5,  0, 0,  4, 1, 0, 0);
        step("halt5",  0, 6,  0, 0,  5, 1, 1, 1);
        step("hlt0",   0, 6,  0, 0, -1, 0, 1, 1);
        step("hlt1",   0, 6,  0, 0, -1, 0, 1, 1);
        step("rsthlt", 1, 6,  0, 0,  0, 0, 0, 0);
        step("fill2",  0, 0,  0, 0, -1, 0, 0, 0);
        step("re0",    0, 1,  0, 0,  0, 1, 0, 0);
        // reset during stall
        step("hold0",  0, 2,  1, 0,  0, 1, 0, 1);
        step("rststl", 1, 2,  1, 0,  0, 0, 0, 1);
        step("rst2",   1, 0,  0, 0,  0, 0, 0, 0);
        // stall in FILL then wrap 15 -> 0
        step("fillst", 0, 15, 1, 0, -1, 0, 0, 1);
        step("fill3",  0, 15, 0, 0, -1, 0, 0, 0);
        step("w15",    0, 0,  0, 0, 15, 1, 0, 0);
        step("w0",     0, 1,  0, 0,  0, 1, 0, 0);
        step("w1",     0, 2,  0, 0,  1, 1, 0, 0);

        repeat (3) @(negedge clk);
        if (q.size() != 0) begin
            n_err++;
            $display("FAIL drain: got %0d pending, want 0", q.size());
        end
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
